btn_intr_ctrl: RTL and testbench
================================

Name: btn_intr_ctrl

Overview:
- Downstream consumer of the debounce/one-shot outputs.
- Collects single-cycle button pulses from up to N debounced sources into sticky pending flags and applies an enable mask.
- Raises one level-sensitive INTR line to the OTTER CPU and reports the lowest-index active source as CAUSE_ID.
- Clears the served flag on CPU acknowledge, then holds INTR low for a short holdoff so the CPU sees the deassertion.

Parameters:
N, 4, number of pulse sources (2..16).
HOLDOFF_CLKS, 8'h04, clocks INTR is held low after an acknowledge (1..255).
RESET_MASK, all ones (N bits), value loaded into MASK on reset.

Ports:
CLK  in  1  OTTER 50 MHz clock.
RST_N  in  1  asynchronous active-low reset.
SRC_PULSE  in  N  one-shot pulses from debounce_one_shot instances, one bit per source.
MASK_WE  in  1  write strobe for the mask register.
MASK_DIN  in  N  new mask value; 1 = source enabled.
CLR_WE  in  1  write strobe for write-1-to-clear of pending flags.
CLR_DIN  in  N  bits to clear in PENDING.
INTR_ACK  in  1  CPU acknowledge pulse, asserted when the CPU takes the trap.
INTR  out  1  interrupt request to the CPU.
CAUSE_ID  out  clog2(N)  index of the source being requested.
PENDING  out  N  sticky pending flags, readable over MMIO.
MASK  out  N  current mask.
OVERRUN  out  N  sticky flag: a pulse arrived while that source was already pending.

Behaviour:
- Reset (RST_N=0, asynchronous):
  - PENDING=0, OVERRUN=0, MASK=RESET_MASK, CAUSE_ID=0, INTR=0.
  - Holdoff counter=0, state=ST_IDLE.
- Pending register, per bit i, each clock:
  - Next value = SRC_PULSE[i] | (PENDING[i] & ~clr_i).
  - clr_i = (CLR_WE & CLR_DIN[i]) | (ack clear of source i).
  - Set wins over clear in the same cycle.
- Mask:
  - On MASK_WE, MASK<=MASK_DIN on the next edge.
  - Masking never clears PENDING.
- Active set = PENDING & MASK.
- FSM states ST_IDLE, ST_REQ, ST_HOLD. INTR is a Moore output, 1 only in ST_REQ.
- ST_IDLE:
  - If the active set is nonzero: NS=ST_REQ, and CAUSE_ID is latched as the lowest set index of the active set.
  - Otherwise stay.
- ST_REQ:
  - INTR_ACK=1: clear PENDING[CAUSE_ID], load holdoff counter=0, NS=ST_HOLD.
  - Else if PENDING[CAUSE_ID]&MASK[CAUSE_ID] has gone to 0 (software clear or mask): NS=ST_IDLE with no ack. INTR falls on the next edge.
  - Else stay. CAUSE_ID is frozen while in ST_REQ, even if a lower-index source becomes active.
- ST_HOLD:
  - Counter increments each clock.
  - When counter==HOLDOFF_CLKS-1: counter reset, NS=ST_IDLE.
  - INTR stays 0 for exactly HOLDOFF_CLKS clocks.
- Latency:
  - The pulse sampled at edge k sets PENDING at k.
  - INTR is high after edge k+1, i.e. 2 clocks from pulse to INTR with an idle FSM.
- INTR_ACK outside ST_REQ is ignored.
- Ack and a new pulse on the same source in the same cycle:
  - PENDING stays 1.
  - After the holdoff the source is requested again.
- Counters: 8-bit, unsigned, no wrap possible because the compare terminates the count.

Optional Feature:
- Macro: BTN_INTR_OVERRUN_EN.
- Defined:
  - OVERRUN[i] sets when SRC_PULSE[i]=1 while PENDING[i]=1 and PENDING[i] is not cleared that cycle.
  - OVERRUN[i] clears only via CLR_WE&CLR_DIN[i]; set wins.
- Undefined: OVERRUN is tied to 0 and no overrun flops are built.

Test Plan (N=4, HOLDOFF_CLKS=2):
- Reset, then 1-cycle pulse SRC_PULSE=4'b0100 → PENDING=4'b0100 after the next edge; INTR=1 two clocks after the pulse; CAUSE_ID=2. Then INTR_ACK → PENDING=0; INTR low 2 clocks; FSM back in ST_IDLE.
- Simultaneous pulses 4'b1010 → CAUSE_ID=1 first. After ack and holdoff → INTR re-rises with CAUSE_ID=3.
- MASK_DIN=4'b1110, pulse on bit 0 → PENDING=4'b0001, INTR stays 0. Then MASK_DIN=4'b1111 → INTR rises 1 clock after the mask write lands; CAUSE_ID=0.
- In ST_REQ with CAUSE_ID=2, CLR_WE with CLR_DIN=4'b0100 → INTR falls next edge, PENDING=0, no holdoff.
- Assert RST_N=0 mid-ST_REQ between edges → INTR, PENDING and OVERRUN go to 0 immediately, without waiting for a clock edge; MASK=4'b1111.
- With BTN_INTR_OVERRUN_EN defined: two pulses on bit 3 with no ack → OVERRUN=4'b1000. CLR_DIN=4'b1000 → OVERRUN=0 and PENDING[3]=0. Without the macro defined, OVERRUN stays 0 throughout.

Source files
------------

// File: rtl/btn_intr_ctrl.sv
// Button interrupt controller: sticky pending flags, enable mask and one level INTR with cause ID.
// Optional overrun tracking is built only when BTN_INTR_OVERRUN_EN is defined.
module btn_intr_ctrl #(
   parameter int             N            = 4,
   parameter logic [7:0]     HOLDOFF_CLKS = 8'h04,
   parameter logic [N-1:0]   RESET_MASK   = {N{1'b1}},
   localparam int            CW           = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk_i,
   input  logic          rst_n_i,
   input  logic [N-1:0]  src_pulse_i,
   input  logic          mask_we_i,
   input  logic [N-1:0]  mask_din_i,
   input  logic          clr_we_i,
   input  logic [N-1:0]  clr_din_i,
   input  logic          intr_ack_i,
   output logic          intr_o,
   output logic [CW-1:0] cause_id_o,
   output logic [N-1:0]  pending_o,
   output logic [N-1:0]  mask_o,
   output logic [N-1:0]  overrun_o
);

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_HOLD} state_t;

   state_t        state_q, state_d;
   logic [7:0]    cnt_q, cnt_d;
   logic [CW-1:0] cause_q, cause_d;
   logic [N-1:0]  pending_q, pending_d;
   logic [N-1:0]  mask_q, mask_d;
   logic [N-1:0]  active;
   logic [N-1:0]  ack_clr;
   logic [N-1:0]  clr_vec;
   logic [CW-1:0] low_idx;
   logic          ack_fire;
   logic          cause_live;

   assign active     = pending_q & mask_q;
   assign ack_fire   = (state_q == ST_REQ) & intr_ack_i;
   assign cause_live = pending_q[cause_q] & mask_q[cause_q];

   // Descending scan so the last hit is the lowest set index.
   always_comb begin
      low_idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (active[i]) low_idx = CW'(i);
      end
   end

   assign clr_vec   = ({N{clr_we_i}} & clr_din_i) | ack_clr;
   assign pending_d = src_pulse_i | (pending_q & ~clr_vec);
   assign mask_d    = mask_we_i ? mask_din_i : mask_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         pending_q <= '0;
         mask_q    <= RESET_MASK;
      end else begin
         pending_q <= pending_d;
         mask_q    <= mask_d;
      end
   end

   // FSM state register (holdoff counter and latched cause travel with it)
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         cause_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cause_q <= cause_d;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cause_d = cause_q;
      unique case (state_q)
         ST_IDLE: begin
            if (|active) begin
               state_d = ST_REQ;
               cause_d = low_idx;
            end
         end
         ST_REQ: begin
            if (intr_ack_i) begin
               state_d = ST_HOLD;
               cnt_d   = '0;
            end else if (!cause_live) begin
               state_d = ST_IDLE;
            end
         end
         ST_HOLD: begin
            if (cnt_q == HOLDOFF_CLKS - 8'd1) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM outputs: Moore INTR plus the one-hot clear of the served source
   always_comb begin
      intr_o  = (state_q == ST_REQ);
      ack_clr = '0;
      if (ack_fire) ack_clr[cause_q] = 1'b1;
   end

   assign cause_id_o = cause_q;
   assign pending_o  = pending_q;
   assign mask_o     = mask_q;

`ifdef BTN_INTR_OVERRUN_EN
   logic [N-1:0] ovr_q, ovr_d;

   // A repeat pulse only counts as overrun if the flag it lands on survives this cycle.
   assign ovr_d = (src_pulse_i & pending_q & ~clr_vec) |
                  (ovr_q & ~({N{clr_we_i}} & clr_din_i));

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) ovr_q <= '0;
      else          ovr_q <= ovr_d;
   end

   assign overrun_o = ovr_q;
`else
   assign overrun_o = '0;
`endif

endmodule

// File: tb/tb_btn_intr_ctrl.sv
// Directed bench for btn_intr_ctrl at N=4, HOLDOFF_CLKS=2; overrun expectations follow BTN_INTR_OVERRUN_EN.
module tb_btn_intr_ctrl;
  logic       gclk = 1'b0;
  logic       grst_n;
  logic [3:0] src, mdin, cdin, ovr, pend, msk;
  logic       mwe, cwe, ack, intr;
  logic [1:0] cause;
  int         n_chk = 0;
  int         n_err = 0;

`ifdef BTN_INTR_OVERRUN_EN
  localparam logic [3:0] OVR3 = 4'b1000;
`else
  localparam logic [3:0] OVR3 = 4'b0000;
`endif

  always #5 gclk = ~gclk;

  btn_intr_ctrl #(.N(4), .HOLDOFF_CLKS(8'd2)) dut (
    .clk_i(gclk), .rst_n_i(grst_n), .src_pulse_i(src),
    .mask_we_i(mwe), .mask_din_i(mdin), .clr_we_i(cwe), .clr_din_i(cdin),
    .intr_ack_i(ack), .intr_o(intr), .cause_id_o(cause),
    .pending_o(pend), .mask_o(msk), .overrun_o(ovr)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // advance one edge; inputs change and outputs are sampled 1ns after it
  task automatic tick();
    @(posedge gclk);
    #1;
  endtask

  task automatic idle_in();
    src = '0; mwe = 0; mdin = '0; cwe = 0; cdin = '0; ack = 0;
  endtask

  initial begin
    idle_in();
    grst_n = 0;
    #12;
    chk("rst_intr", intr, 0);
    chk("rst_pend", pend, 4'b0000);
    chk("rst_mask", msk, 4'b1111);
    chk("rst_ovr", ovr, 4'b0000);
    chk("rst_cause", cause, 0);
    tick(); grst_n = 1; tick();

    // single pulse, 2-clock latency, ack and holdoff
    src = 4'b0100; tick(); src = '0;
    chk("t1_pend", pend, 4'b0100);
    chk("t1_intr_k", intr, 0);
    tick();
    chk("t1_intr", intr, 1);
    chk("t1_cause", cause, 2);
    ack = 1; tick(); ack = 0;
    chk("t1_ack_pend", pend, 4'b0000);
    chk("t1_ack_intr", intr, 0);
    tick(); chk("t1_hold", intr, 0);
    tick(); chk("t1_idle", intr, 0);

    // simultaneous pulses: lowest index first, re-request after holdoff
    src = 4'b1010; tick(); src = '0;
    chk("t2_pend", pend, 4'b1010);
    tick();
    chk("t2_intr", intr, 1);
    chk("t2_cause1", cause, 1);
    ack = 1; tick(); ack = 0;
    chk("t2_pend_ack", pend, 4'b1000);
    chk("t2_h0", intr, 0);
    tick(); chk("t2_h1", intr, 0);
    tick(); chk("t2_idle", intr, 0);
    tick();
    chk("t2_rerise", intr, 1);
    chk("t2_cause3", cause, 3);
    ack = 1; tick(); ack = 0;
    chk("t2_pend0", pend, 4'b0000);
    tick(); tick();

    // masked source stays pending, ack in idle is ignored, unmask raises INTR
    mwe = 1; mdin = 4'b1110; tick(); mwe = 0;
    chk("t3_mask", msk, 4'b1110);
    src = 4'b0001; tick(); src = '0;
    chk("t3_pend", pend, 4'b0001);
    chk("t3_intr0", intr, 0);
    ack = 1; tick(); ack = 0;
    chk("t3_ack_ign", pend, 4'b0001);
    tick(); chk("t3_intr1", intr, 0);
    mwe = 1; mdin = 4'b1111; tick(); mwe = 0;
    chk("t3_mask2", msk, 4'b1111);
    chk("t3_intr2", intr, 0);
    tick();
    chk("t3_rise", intr, 1);
    chk("t3_cause", cause, 0);
    cwe = 1; cdin = 4'b0001; tick(); cwe = 0; cdin = '0;
    tick(); chk("t3_drop", intr, 0);

    // software clear in ST_REQ drops INTR with no holdoff
    src = 4'b0100; tick(); src = '0; tick();
    chk("t4_intr", intr, 1);
    chk("t4_cause", cause, 2);
    cwe = 1; cdin = 4'b0100; tick(); cwe = 0; cdin = '0;
    chk("t4_pend", pend, 4'b0000);
    tick(); chk("t4_fall", intr, 0);
    src = 4'b0010; tick(); src = '0; tick();
    chk("t4_nohold", intr, 1);
    chk("t4_cause1", cause, 1);

    // cause frozen in ST_REQ; ack + pulse on the same source keeps it pending
    src = 4'b0001; tick(); src = '0;
    chk("t5_frozen", cause, 1);
    chk("t5_pend", pend, 4'b0011);
    ack = 1; src = 4'b0010; tick(); ack = 0; src = '0;
    chk("t5_setwins", pend, 4'b0011);
    chk("t5_no_ovr", ovr, 4'b0000);
    tick(); tick(); tick();
    chk("t5_rereq", intr, 1);
    chk("t5_cause0", cause, 0);

    // asynchronous reset between edges while in ST_REQ
    mwe = 1; mdin = 4'b0111; tick(); mwe = 0;
    chk("t6_mask", msk, 4'b0111);
    #2 grst_n = 0; #1;
    chk("t6_intr", intr, 0);
    chk("t6_pend", pend, 4'b0000);
    chk("t6_ovr", ovr, 4'b0000);
    chk("t6_mask_rst", msk, 4'b1111);
    chk("t6_cause", cause, 0);
    tick(); grst_n = 1; tick();

    // overrun: repeated pulse on a pending source, cleared by write-1-to-clear
    src = 4'b1000; tick(); src = '0; tick();
    chk("t7_intr", intr, 1);
    src = 4'b1000; tick(); src = '0;
    chk("t7_pend", pend, 4'b1000);
    chk("t7_ovr", ovr, OVR3);
    cwe = 1; cdin = 4'b1000; tick(); cwe = 0; cdin = '0;
    chk("t7_pend_clr", pend, 4'b0000);
    chk("t7_ovr_clr", ovr, 4'b0000);
    tick(); chk("t7_fall", intr, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
